// File: rtl/sig_pkg.sv
// sig_pkg: shared width helper and FIFO status record for the sig_* pipeline stages
package sig_pkg;
    function automatic int clog2_f(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    typedef struct packed {
        logic full;
        logic almost_full;
        logic ovf;
    } fifo_status_t;
endpackage

// File: rtl/sig_fifo_mem.sv
// sig_fifo_mem: DEPTH x WIDTH register array, one sync write port and one async read port
module sig_fifo_mem #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sig_vld_fifo.sv
// sig_vld_fifo: show-ahead FIFO buffering a backpressure-free valid stream for a valid/ready consumer
module sig_vld_fifo
    import sig_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 4,
    parameter int AF_LVL = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   almost_full,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int AW = clog2_f(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic ovf_q, push, pop, drop;
    fifo_status_t st;
    assign st = '{full: count == CW'(DEPTH), almost_full: count >= CW'(AF_LVL), ovf: ovf_q};
    assign full        = st.full;
    assign almost_full = st.almost_full;
    assign ovf         = st.ovf;
    assign out_vld     = count != '0;
    assign out_data    = out_vld ? rdata : '0;
    assign pop  = out_vld & out_rdy;
    // a full FIFO still accepts a beat when the head leaves in the same cycle
    assign push = in_vld & (!full | pop);
    assign drop = in_vld & full & !pop;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            ovf_q <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        end
    end
    sig_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk  (clk),
        .we   (push & !rst),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_sig_vld_fifo.sv
// tb_sig_vld_fifo: directed vector table plus hand sequences for bypass and pointer wrap
module tb_sig_vld_fifo;
    logic clk = 0, rst = 0, in_vld = 0, out_rdy = 0, ovf_clr = 0;
    logic [7:0] in_data = 0, out_data;
    logic out_vld, full, almost_full, ovf;
    logic [2:0] count;
    int n_vec = 0, n_err = 0;
    typedef struct {
        logic rst, iv;
        logic [7:0] d;
        logic rdy, clr;
        logic [7:0] ed;
        logic [2:0] ec;
        logic ef, ea, eo;
    } vec_t;
    vec_t v[$];
    sig_vld_fifo #(.WIDTH(8), .DEPTH(4), .AF_LVL(3)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .count(count), .full(full), .almost_full(almost_full),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic r, iv, input logic [7:0] d, input logic rdy, clr,
                                input logic [7:0] ed, input logic [2:0] ec, input logic ef, ea, eo);
        vec_t x;
        x = '{r, iv, d, rdy, clr, ed, ec, ef, ea, eo};
        return x;
    endfunction
    task automatic fill4(input logic eo);
        v.push_back(mk(0, 1, 1, 0, 0, 1, 1, 0, 0, eo));
        v.push_back(mk(0, 1, 2, 0, 0, 1, 2, 0, 0, eo));
        v.push_back(mk(0, 1, 3, 0, 0, 1, 3, 0, 1, eo));
        v.push_back(mk(0, 1, 4, 0, 0, 1, 4, 1, 1, eo));
    endtask
    initial begin
        int q[$];
        int pushed;
        logic iv, rdy, p_pop, p_push;
        // reset with a live producer
        v.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0));
        // streaming with consumer always ready
        v.push_back(mk(0, 1, 1, 1, 0, 1, 1, 0, 0, 0));
        v.push_back(mk(0, 1, 2, 1, 0, 2, 1, 0, 0, 0));
        v.push_back(mk(0, 1, 3, 1, 0, 3, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // fill, overflow, drain
        fill4(0);
        v.push_back(mk(0, 1, 5, 0, 0, 1, 4, 1, 1, 1));
        v.push_back(mk(0, 0, 0, 1, 0, 2, 3, 0, 1, 1));
        v.push_back(mk(0, 0, 0, 1, 0, 3, 2, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // full with simultaneous push and pop
        fill4(0);
        v.push_back(mk(0, 1, 9, 1, 0, 2, 4, 1, 1, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 3, 3, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 4, 2, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 9, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // ovf set beats clear, clear alone, then mid-operation reset
        fill4(0);
        v.push_back(mk(0, 1, 5, 0, 0, 1, 4, 1, 1, 1));
        v.push_back(mk(0, 1, 6, 0, 1, 1, 4, 1, 1, 1));
        v.push_back(mk(0, 0, 0, 0, 1, 1, 4, 1, 1, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 2, 3, 0, 1, 0));
        v.push_back(mk(1, 1, 7, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 7, 0, 0, 7, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 1, 8, 0, 0, 8, 1, 0, 0, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        foreach (v[i]) begin
            @(negedge clk);
            rst = v[i].rst; in_vld = v[i].iv; in_data = v[i].d;
            out_rdy = v[i].rdy; ovf_clr = v[i].clr;
            @(posedge clk);
            #1;
            n_vec++;
            chk($sformatf("v%0d out_vld", i), 32'(out_vld), 32'(v[i].ec != 0));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(v[i].ed));
            chk($sformatf("v%0d count", i), 32'(count), 32'(v[i].ec));
            chk($sformatf("v%0d full", i), 32'(full), 32'(v[i].ef));
            chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(v[i].ea));
            chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(v[i].eo));
        end
        // no bypass: empty FIFO stays empty during the push cycle
        @(negedge clk);
        rst = 0; in_vld = 1; in_data = 8'h55; out_rdy = 1; ovf_clr = 0;
        #1;
        n_vec++;
        chk("bypass out_vld", 32'(out_vld), 0);
        chk("bypass out_data", 32'(out_data), 0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("bypass late out_vld", 32'(out_vld), 1);
        chk("bypass late out_data", 32'(out_data), 32'h55);
        @(negedge clk);
        in_vld = 0;
        @(posedge clk);
        #1;
        n_vec++;
        chk("bypass drain count", 32'(count), 0);
        // wrap with random stalls against a queue scoreboard
        pushed = 0;
        for (int c = 0; c < 400 && (pushed < 10 || q.size() > 0); c++) begin
            @(negedge clk);
            n_vec++;
            chk("wrap out_vld", 32'(out_vld), 32'(q.size() > 0));
            chk("wrap out_data", 32'(out_data), q.size() > 0 ? q[0] : 0);
            chk("wrap count", 32'(count), q.size());
            iv = pushed < 10 && $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 2) != 0;
            p_pop = q.size() > 0 && rdy;
            p_push = iv && (q.size() < 4 || p_pop);
            in_vld = iv; in_data = 8'(pushed + 16); out_rdy = rdy;
            @(posedge clk);
            if (p_pop) void'(q.pop_front());
            if (p_push) begin
                q.push_back(pushed + 16);
                pushed++;
            end
        end
        @(negedge clk);
        in_vld = 0; out_rdy = 0;
        n_vec++;
        chk("wrap pushed", pushed, 10);
        chk("wrap end count", 32'(count), 0);
        chk("wrap end out_vld", 32'(out_vld), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
